// File: rtl/main_mem_responder_if.sv
// Request/response bus between the cache miss path (master) and the backing memory (slave).
interface main_mem_responder_if;
  logic        req;
  logic        we;
  logic [21:0] add;
  logic [31:0] din;
  logic        busy;
  logic        ack;
  logic [31:0] dout;
  logic        err;

  modport master (output req, we, add, din, input busy, ack, dout, err);
  modport slave  (input req, we, add, din, output busy, ack, dout, err);
endinterface

// File: rtl/main_mem_responder.sv
// Backing-memory model for the cache fill/write-back path: one word per request,
// fixed access latency, one-cycle ack, sticky protocol-error flag.
module main_mem_responder #(
  parameter int LATENCY = 4,   // 1..15
  parameter int MEM_AW  = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  main_mem_responder_if.slave  bus
);

  localparam int DEPTH = 1 << MEM_AW;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef logic [DEPTH-1:0][31:0] mem_t;

  function automatic mem_t mem_init();
    mem_t m;
    for (int i = 0; i < DEPTH; i++) m[i] = 32'(i);
    return m;
  endfunction

  // Power-up image: word i holds i.
  mem_t mem_q = mem_init();

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [MEM_AW-1:0]   idx_q, idx_d;
  logic                we_q, we_d;
  logic [31:0]         din_q, din_d;
  logic [31:0]         dout_q, dout_d;
  logic                err_q, err_d;
  logic                accept;
  logic                do_access;
  logic                unused_add;

  assign accept     = bus.req && (state_q == IDLE || state_q == RESP);
  assign do_access  = (state_q == WAIT) && (cnt_q == 4'd0);
  assign unused_add = ^bus.add;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      din_q   <= '0;
      dout_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      din_q   <= din_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
    end
  end

  // NOTE: storage is deliberately left out of the reset domain; reset only
  // aborts the transaction, it never clears memory contents.
  always_ff @(posedge clk) begin
    if (do_access && we_q) mem_q[idx_q] <= din_q;
  end

  // NOTE: every signal gets a default at the top so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    we_d    = we_q;
    din_d   = din_q;
    dout_d  = dout_q;
    err_d   = err_q;

    unique case (state_q)
      IDLE: if (accept) state_d = WAIT;
      WAIT: begin
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        else               state_d = RESP;
      end
      RESP: state_d = accept ? WAIT : IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      idx_d = bus.add[MEM_AW+1:2];
      we_d  = bus.we;
      din_d = bus.din;
      cnt_d = 4'(LATENCY - 1);
    end

    if (do_access) dout_d = we_q ? din_q : mem_q[idx_q];

    // Requests during WAIT are dropped; misaligned ones are still serviced.
    if ((bus.req && state_q == WAIT) || (accept && bus.add[1:0] != 2'b00))
      err_d = 1'b1;
  end

  always_comb begin
    bus.busy = (state_q == WAIT);
    bus.ack  = (state_q == RESP);
    bus.dout = dout_q;
    bus.err  = err_q;
  end

endmodule

// File: doc/main_mem_responder.md
# main_mem_responder

Backing-memory responder for the direct-mapped cache. It is the far end of the cache's miss/fill path: it accepts one word read (line fill) or write (write-back) per request, holds the request for a fixed access latency, then returns the data with a one-cycle acknowledge. It is a behavioural, simulation-oriented memory model with a cycle-accurate handshake. Its purpose is to give the cache realistic, non-zero miss latency in place of same-cycle data.

## Interface
Parameters:
- LATENCY, 4: cycles from request acceptance to ack; legal range 1..15.
- MEM_AW, 12: word-address bits implemented; the word index is add[MEM_AW+1:2]; higher address bits alias.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req  input  1  request strobe, sampled on the rising edge.
- we  input  1  1 = write (write-back), 0 = read (fill); sampled with req.
- add  input  22  byte address, same format as the cache address; add[1:0] must be 0.
- din  input  32  write data; sampled with req.
- busy  output  1  high while a request is in flight (WAIT state).
- ack  output  1  one-cycle completion pulse.
- dout  output  32  response data; valid when ack=1; held until the next ack.
- err  output  1  sticky protocol-error flag.

## Operation
- Storage: 2^MEM_AW × 32-bit words.
  - At time zero, each word mem[i] is initialised to i, zero-extended to 32 bits.
  - Reset does not clear storage.
- State machine, with states IDLE, WAIT and RESP:
  - Acceptance condition: `req=1` while in IDLE or RESP.
  - On acceptance: capture the word index, `we` and `din`; load `cnt = LATENCY-1`; go to WAIT.
  - WAIT: on each edge, if `cnt != 0`, decrement `cnt`. If `cnt == 0`, perform the access and go to RESP.
  - RESP: lasts exactly one cycle with `ack=1`. On its closing edge, go to WAIT if a new `req` is accepted, otherwise go to IDLE.
- Access is performed on the edge entering RESP:
  - Read: `dout <= mem[idx]`.
  - Write: `mem[idx] <= din_captured` and `dout <= din_captured` (echo).
- `busy = 1` exactly while in WAIT. It is 0 in IDLE and RESP, so back-to-back requests are possible with no idle cycle.
- `err` is set (and stays set until reset) by either of these:
  - `req=1` while in WAIT. The request is ignored; nothing is captured or queued.
  - An accepted request with `add[1:0] != 0`. The request is still serviced; the low bits are ignored.
- Outputs change only in response to `clk` or `rst`; there is no combinational path from inputs to outputs.

## Timing
- Reset values: state IDLE, `busy=0`, `ack=0`, `dout=32'h0`, `err=0`, `cnt=0`.
- Latency: a request accepted at edge E0 gives `ack=1` in the cycle following edge E0+LATENCY. With LATENCY=1, `ack` is high in the cycle after E1.
- Throughput: one request per LATENCY+1 cycles when `req` is reasserted during the RESP cycle.
- Read-after-write to the same word:
  - The write commits on entry to RESP.
  - A read accepted during that RESP cycle returns the new data.
- Reset during WAIT: the transaction is dropped. A pending write is not committed, and `ack` is never produced.
- Reset during RESP: the write, if any, has already been committed; `ack` and `dout` are cleared immediately (asynchronous reset).
- `req` held high continuously:
  - A new request is accepted at each RESP cycle.
  - Every cycle spent in WAIT sets `err`.
  - The requester must therefore drop `req` after acceptance, or gate it with `busy`.

## Test plan
- Reset then single read, LATENCY=4, MEM_AW=12:
  - Stimulus: `req=1, we=0, add=22'h000010` for one cycle.
  - Required: `busy=1` for 4 cycles, then `ack=1` for one cycle with `dout=32'h4`. `err` stays 0.
- Write then read back:
  - Stimulus: write `add=22'h000020`, `din=32'hDEADBEEF`; then a read of the same address accepted during the write's RESP cycle.
  - Required: first ack gives `dout=32'hDEADBEEF`; second ack, 5 cycles later, gives `dout=32'hDEADBEEF`.
- Aliasing:
  - Stimulus: read `add=22'h004010`, which has index 4 with MEM_AW=12.
  - Required: `dout=32'h4`, i.e. the same word as address `22'h000010`.
- Protocol errors:
  - `req` pulsed during WAIT → `err=1` and stays 1; the in-flight ack is unaffected; no extra ack appears.
  - Read of `add=22'h000013` → `err=1` and `dout=32'h4`.
- Reset mid-write:
  - Stimulus: write `32'h12345678` to `22'h000040`; assert `rst` on cycle 2 of WAIT.
  - Required: no ack; a subsequent read of `22'h000040` returns `32'h10`.
- LATENCY=1 back-to-back:
  - Stimulus: three reads at indices 1, 2, 3, each reasserted during the previous RESP cycle.
  - Required: ack every 2nd cycle, with `dout` = 1, 2, 3.
